// File: rtl/keypad_code_entry.sv
// Turns single-key press events from the keypad manager into BCD digit entry
// with backspace ('*'), commit ('#') and an idle timeout for partial entries.
module keypad_code_entry #(
  parameter int DIGITS      = 4,
  parameter int TIMEOUT_CYC = 50_000_000
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic [11:0]         i_key_push,
  output logic                o_digit_valid,
  output logic [3:0]          o_digit,
  output logic [4*DIGITS-1:0] o_entry,
  output logic [3:0]          o_entry_len,
  output logic                o_full,
  output logic                o_code_valid,
  output logic [4*DIGITS-1:0] o_code,
  output logic [3:0]          o_code_len,
  output logic                o_timeout
);

  localparam int EW = 4 * DIGITS;
  localparam int CW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam int TO_LAST_I = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;
  localparam logic [CW-1:0] TO_LAST = TO_LAST_I[CW-1:0];
  localparam logic [3:0] DIGITS_L = 4'(DIGITS);

  typedef enum logic [1:0] {IDLE, ENTRY, COMMIT} state_t;

  state_t        state_reg, state_next;
  logic [11:0]   prev_reg;
  logic [EW-1:0] entry_reg, entry_next;
  logic [3:0]    len_reg, len_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [EW-1:0] code_reg, code_next;
  logic [3:0]    code_len_reg, code_len_next;
  logic          digit_valid_reg, digit_valid_next;
  logic [3:0]    digit_reg, digit_next;
  logic          code_valid_reg, code_valid_next;
  logic          timeout_reg, timeout_next;
  logic          full_reg;

  logic       press;
  logic [3:0] key_idx;
  logic [3:0] key_digit;

  // An event needs a fully released keypad on the previous cycle and exactly one key now.
  assign press = (prev_reg == 12'd0) && $onehot(i_key_push);

  always_comb begin
    key_idx = 4'd0;
    for (int i = 0; i < 12; i++) begin
      if (i_key_push[i]) key_idx = 4'(i);
    end
    key_digit = (key_idx == 4'd10) ? 4'd0 : key_idx + 4'd1;
  end

  always_comb begin
    state_next       = (state_reg == COMMIT) ? IDLE : state_reg;
    entry_next       = entry_reg;
    len_next         = len_reg;
    cnt_next         = cnt_reg;
    code_next        = code_reg;
    code_len_next    = code_len_reg;
    digit_valid_next = 1'b0;
    digit_next       = digit_reg;
    code_valid_next  = 1'b0;
    timeout_next     = 1'b0;

    if (press) begin
      cnt_next = '0;
      if (key_idx == 4'd9) begin
        if (len_reg != 4'd0) begin
          entry_next = entry_reg >> 4;
          len_next   = len_reg - 4'd1;
          if (len_reg == 4'd1) state_next = IDLE;
        end
      end else if (key_idx == 4'd11) begin
        if (len_reg != 4'd0) begin
          code_next       = entry_reg;
          code_len_next   = len_reg;
          code_valid_next = 1'b1;
          entry_next      = '0;
          len_next        = 4'd0;
          state_next      = COMMIT;
        end
      end else if (len_reg < DIGITS_L) begin
        entry_next       = (entry_reg << 4) | EW'(key_digit);
        len_next         = len_reg + 4'd1;
        digit_valid_next = 1'b1;
        digit_next       = key_digit;
        state_next       = ENTRY;
      end
    end else if (state_reg == ENTRY && TIMEOUT_CYC > 0) begin
      if (cnt_reg == TO_LAST) begin
        entry_next   = '0;
        len_next     = 4'd0;
        cnt_next     = '0;
        timeout_next = 1'b1;
        state_next   = IDLE;
      end else begin
        cnt_next = cnt_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_reg       <= IDLE;
      prev_reg        <= '0;
      entry_reg       <= '0;
      len_reg         <= '0;
      cnt_reg         <= '0;
      code_reg        <= '0;
      code_len_reg    <= '0;
      digit_valid_reg <= 1'b0;
      digit_reg       <= '0;
      code_valid_reg  <= 1'b0;
      timeout_reg     <= 1'b0;
      full_reg        <= 1'b0;
    end else begin
      state_reg       <= state_next;
      prev_reg        <= i_key_push;
      entry_reg       <= entry_next;
      len_reg         <= len_next;
      cnt_reg         <= cnt_next;
      code_reg        <= code_next;
      code_len_reg    <= code_len_next;
      digit_valid_reg <= digit_valid_next;
      digit_reg       <= digit_next;
      code_valid_reg  <= code_valid_next;
      timeout_reg     <= timeout_next;
      full_reg        <= (len_next == DIGITS_L);
    end
  end

  assign o_digit_valid = digit_valid_reg;
  assign o_digit       = digit_reg;
  assign o_entry       = entry_reg;
  assign o_entry_len   = len_reg;
  assign o_full        = full_reg;
  assign o_code_valid  = code_valid_reg;
  assign o_code        = code_reg;
  assign o_code_len    = code_len_reg;
  assign o_timeout     = timeout_reg;

endmodule

// File: tb/tb_keypad_code_entry.sv
// Directed bench for keypad_code_entry with DIGITS=4, TIMEOUT_CYC=100.
module tb_keypad_code_entry;

  logic        aclk;
  logic        aresetn;
  logic [11:0] i_key_push;
  logic        o_digit_valid;
  logic [3:0]  o_digit;
  logic [15:0] o_entry;
  logic [3:0]  o_entry_len;
  logic        o_full;
  logic        o_code_valid;
  logic [15:0] o_code;
  logic [3:0]  o_code_len;
  logic        o_timeout;

  int tests_run = 0;
  int tests_failed = 0;

  keypad_code_entry #(.DIGITS(4), .TIMEOUT_CYC(100)) dut (
    .aclk(aclk), .aresetn(aresetn), .i_key_push(i_key_push),
    .o_digit_valid(o_digit_valid), .o_digit(o_digit), .o_entry(o_entry),
    .o_entry_len(o_entry_len), .o_full(o_full), .o_code_valid(o_code_valid),
    .o_code(o_code), .o_code_len(o_code_len), .o_timeout(o_timeout)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end else begin
      $display("[TB] ok   %s = 0x%0h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic press(input int idx);
    i_key_push = '0;
    i_key_push[idx] = 1'b1;
    tick();
  endtask

  task automatic release_keys();
    i_key_push = '0;
    tick();
  endtask

  int pulses;

  initial begin
    aresetn    = 1'b0;
    i_key_push = '0;
    repeat (3) @(posedge aclk);
    #1;
    check("rst_entry_len", 32'(o_entry_len), 0);
    check("rst_code", 32'(o_code), 0);
    check("rst_strobes", {29'd0, o_digit_valid, o_code_valid, o_timeout}, 0);
    aresetn = 1'b1;
    tick();

    // '1','2','3','#'
    press(0);  check("d1_valid", 32'(o_digit_valid), 1); check("d1_digit", 32'(o_digit), 1); release_keys();
    press(1);  check("d2_digit", 32'(o_digit), 2); release_keys();
    press(2);  check("d3_digit", 32'(o_digit), 3); check("d3_entry", 32'(o_entry), 32'h0123); release_keys();
    press(11);
    check("c1_valid", 32'(o_code_valid), 1);
    check("c1_code", 32'(o_code), 32'h0123);
    check("c1_len", 32'(o_code_len), 3);
    check("c1_entry_len", 32'(o_entry_len), 0);
    release_keys();
    check("c1_valid_drop", 32'(o_code_valid), 0);

    // '9','0','*','5','#'
    press(8);  release_keys();
    press(10); check("d0_digit", 32'(o_digit), 0); check("d0_entry", 32'(o_entry), 32'h0090); release_keys();
    press(9);  check("bs_len", 32'(o_entry_len), 1); check("bs_entry", 32'(o_entry), 32'h0009); release_keys();
    press(4);  release_keys();
    press(11); check("c2_code", 32'(o_code), 32'h0095); check("c2_len", 32'(o_code_len), 2); release_keys();

    // five digits into a four-digit buffer
    for (int i = 0; i < 4; i++) begin press(i); release_keys(); end
    check("full_flag", 32'(o_full), 1);
    check("full_entry", 32'(o_entry), 32'h1234);
    press(4);
    check("drop_valid", 32'(o_digit_valid), 0);
    check("drop_entry", 32'(o_entry), 32'h1234);
    release_keys();
    press(11); check("c3_code", 32'(o_code), 32'h1234); check("c3_len", 32'(o_code_len), 4);
    check("c3_full_clr", 32'(o_full), 0);
    release_keys();

    // two keys at once: not an event
    i_key_push = 12'h003;
    tick();
    check("multi_valid", 32'(o_digit_valid), 0);
    check("multi_len", 32'(o_entry_len), 0);
    release_keys();

    // one key held for 20 cycles: exactly one event
    pulses = 0;
    i_key_push = '0;
    i_key_push[6] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (o_digit_valid) pulses++;
    end
    release_keys();
    check("held_events", 32'(pulses), 1);
    check("held_len", 32'(o_entry_len), 1);
    press(9); release_keys();

    // lone '#' and '*' at length 0
    press(11);
    check("lone_hash_valid", 32'(o_code_valid), 0);
    check("lone_hash_code", 32'(o_code), 32'h1234);
    release_keys();
    press(9);
    check("lone_star", {30'd0, o_digit_valid, o_code_valid}, 0);
    check("lone_star_len", 32'(o_entry_len), 0);
    release_keys();

    // '7' then idle: timeout on the 100th edge after the press
    press(6);
    i_key_push = '0;
    pulses = 0;
    for (int k = 1; k < 100; k++) begin
      tick();
      if (o_timeout) pulses++;
    end
    check("to_early", 32'(pulses), 0);
    check("to_len_before", 32'(o_entry_len), 1);
    tick();
    check("to_pulse", 32'(o_timeout), 1);
    check("to_len", 32'(o_entry_len), 0);
    check("to_code_kept", 32'(o_code), 32'h1234);
    tick();
    check("to_pulse_drop", 32'(o_timeout), 0);

    // a press on cycle 99 restarts the idle count
    press(6);
    i_key_push = '0;
    for (int k = 1; k < 99; k++) tick();
    press(2);
    check("late_press_len", 32'(o_entry_len), 2);
    i_key_push = '0;
    tick();
    check("late_no_to", 32'(o_timeout), 0);
    check("late_len_kept", 32'(o_entry_len), 2);
    pulses = 0;
    for (int k = 101; k < 199; k++) begin
      tick();
      if (o_timeout) pulses++;
    end
    check("late_to_early", 32'(pulses), 0);
    tick();
    check("late_to_pulse", 32'(o_timeout), 1);
    check("late_to_entry", 32'(o_entry), 0);
    tick();

    // asynchronous reset mid-entry
    press(3); release_keys();
    press(1); release_keys();
    check("pre_rst_entry", 32'(o_entry), 32'h0042);
    #2 aresetn = 1'b0;
    #1;
    check("arst_entry", 32'(o_entry), 0);
    check("arst_len", 32'(o_entry_len), 0);
    check("arst_code", 32'(o_code), 0);
    @(negedge aclk);
    aresetn = 1'b1;
    tick();
    check("arst_no_strobe", {29'd0, o_digit_valid, o_code_valid, o_timeout}, 0);
    press(11);
    check("arst_hash", 32'(o_code_valid), 0);
    release_keys();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
